// File: rtl/control_unit.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/write-back
// and the opcode/funct/overflow exception path through EPC and the handler vector.
module control_unit #(
    parameter int unsigned SP_INIT = 227
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ula_zero,
    input  logic       ula_overflow,
    output logic [1:0] crtl_iord,
    output logic [1:0] crtl_error,
    output logic       crtl_memwrite,
    output logic       crtl_irwrite,
    output logic       crtl_memDataRegWrite,
    output logic       crtl_regwrite,
    output logic [2:0] crtl_regdst,
    output logic [3:0] crtl_memtoreg,
    output logic       crtl_rega,
    output logic       crtl_regb,
    output logic       crtl_regaluout,
    output logic       crtl_regepc,
    output logic       crtl_ulasrca,
    output logic [1:0] crtl_ulasrcb,
    output logic [2:0] ULA_CRTL_out,
    output logic [2:0] crtl_pcsource,
    output logic       PC_w,
    output logic [1:0] crtl_ss,
    output logic       crtl_ls,
    output logic [4:0] state_o
);
    localparam logic [4:0] S_RESET  = 5'd0,  S_FETCH0 = 5'd1,  S_FETCH1 = 5'd2,  S_DECODE = 5'd3,
                           S_R_EXEC = 5'd4,  S_R_WB   = 5'd5,  S_I_EXEC = 5'd6,  S_I_WB   = 5'd7,
                           S_ADDR   = 5'd8,  S_LW_RD0 = 5'd9,  S_LW_RD1 = 5'd10, S_LW_WB  = 5'd11,
                           S_SW_WR  = 5'd12, S_BRANCH = 5'd13, S_JUMP   = 5'd14, S_JAL    = 5'd15,
                           S_JAL_WB = 5'd16, S_EXC0   = 5'd17, S_EXC1   = 5'd18, S_EXC2   = 5'd19,
                           S_EXC3   = 5'd20;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;

    // The stack pointer must sit below the handler vectors at bytes 253/254.
    if (SP_INIT >= 253) begin : g_sp_check
        $error("SP_INIT overlaps the exception handler vectors");
    end

    logic [4:0] state, state_next;
    logic [1:0] err, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            err   <= 2'b00;
        end else begin
            state <= state_next;
            err   <= err_next;
        end
    end

    always_comb begin
        state_next           = state;
        err_next             = err;
        crtl_iord            = 2'b00;
        crtl_memwrite        = 1'b0;
        crtl_irwrite         = 1'b0;
        crtl_memDataRegWrite = 1'b0;
        crtl_regwrite        = 1'b0;
        crtl_regdst          = 3'b000;
        crtl_memtoreg        = 4'b0000;
        crtl_rega            = 1'b0;
        crtl_regb            = 1'b0;
        crtl_regaluout       = 1'b0;
        crtl_regepc          = 1'b0;
        crtl_ulasrca         = 1'b0;
        crtl_ulasrcb         = 2'b00;
        ULA_CRTL_out         = 3'b000;
        crtl_pcsource        = 3'b000;
        PC_w                 = 1'b0;
        crtl_ls              = 1'b0;

        case (state)
            S_RESET: begin
                crtl_regdst   = 3'b011;
                crtl_memtoreg = 4'b1000;
                crtl_regwrite = 1'b1;
                state_next    = S_FETCH0;
            end
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: begin
                crtl_irwrite = 1'b1;
                crtl_ulasrcb = 2'b01;
                ULA_CRTL_out = 3'b001;
                PC_w         = 1'b1;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                crtl_rega      = 1'b1;
                crtl_regb      = 1'b1;
                crtl_ulasrcb   = 2'b11;
                ULA_CRTL_out   = 3'b001;
                crtl_regaluout = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                            state_next = S_R_EXEC;
                        end else begin
                            state_next = S_EXC0;
                            err_next   = 2'b00;
                        end
                    end
                    OP_ADDI:       state_next = S_I_EXEC;
                    OP_LW, OP_SW:  state_next = S_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:          state_next = S_JUMP;
                    OP_JAL:        state_next = S_JAL;
                    default: begin
                        state_next = S_EXC0;
                        err_next   = 2'b00;
                    end
                endcase
            end
            S_R_EXEC: begin
                crtl_ulasrca   = 1'b1;
                crtl_regaluout = 1'b1;
                case (funct)
                    FN_SUB:  ULA_CRTL_out = 3'b010;
                    FN_AND:  ULA_CRTL_out = 3'b011;
                    default: ULA_CRTL_out = 3'b001;
                endcase
                if (ula_overflow && (funct == FN_ADD || funct == FN_SUB)) begin
                    state_next = S_EXC0;
                    err_next   = 2'b01;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_R_WB: begin
                crtl_regdst   = 3'b001;
                crtl_memtoreg = 4'b0001;
                crtl_regwrite = 1'b1;
                state_next    = S_FETCH0;
            end
            S_I_EXEC: begin
                crtl_ulasrca   = 1'b1;
                crtl_ulasrcb   = 2'b10;
                ULA_CRTL_out   = 3'b001;
                crtl_regaluout = 1'b1;
                if (ula_overflow) begin
                    state_next = S_EXC0;
                    err_next   = 2'b01;
                end else begin
                    state_next = S_I_WB;
                end
            end
            S_I_WB: begin
                crtl_memtoreg = 4'b0001;
                crtl_regwrite = 1'b1;
                state_next    = S_FETCH0;
            end
            S_ADDR: begin
                crtl_ulasrca   = 1'b1;
                crtl_ulasrcb   = 2'b10;
                ULA_CRTL_out   = 3'b001;
                crtl_regaluout = 1'b1;
                state_next     = (opcode == OP_LW) ? S_LW_RD0 : S_SW_WR;
            end
            S_LW_RD0: begin
                crtl_iord  = 2'b10;
                state_next = S_LW_RD1;
            end
            S_LW_RD1: begin
                crtl_iord            = 2'b10;
                crtl_memDataRegWrite = 1'b1;
                state_next           = S_LW_WB;
            end
            S_LW_WB: begin
                crtl_memtoreg = 4'b0100;
                crtl_regwrite = 1'b1;
                state_next    = S_FETCH0;
            end
            S_SW_WR: begin
                crtl_iord     = 2'b10;
                crtl_memwrite = 1'b1;
                state_next    = S_FETCH0;
            end
            S_BRANCH: begin
                crtl_ulasrca  = 1'b1;
                ULA_CRTL_out  = 3'b010;
                crtl_pcsource = 3'b001;
                PC_w          = (opcode == OP_BEQ) ? ula_zero : ~ula_zero;
                state_next    = S_FETCH0;
            end
            S_JUMP: begin
                crtl_pcsource = 3'b010;
                PC_w          = 1'b1;
                state_next    = S_FETCH0;
            end
            S_JAL: begin
                crtl_regaluout = 1'b1;
                state_next     = S_JAL_WB;
            end
            S_JAL_WB: begin
                crtl_regdst   = 3'b010;
                crtl_memtoreg = 4'b0001;
                crtl_regwrite = 1'b1;
                crtl_pcsource = 3'b010;
                PC_w          = 1'b1;
                state_next    = S_FETCH0;
            end
            S_EXC0: begin
                crtl_ulasrcb = 2'b01;
                ULA_CRTL_out = 3'b010;
                crtl_regepc  = 1'b1;
                state_next   = S_EXC1;
            end
            S_EXC1: begin
                crtl_iord  = 2'b01;
                state_next = S_EXC2;
            end
            S_EXC2: begin
                crtl_iord            = 2'b01;
                crtl_memDataRegWrite = 1'b1;
                state_next           = S_EXC3;
            end
            S_EXC3: begin
                crtl_ls       = 1'b1;
                crtl_pcsource = 3'b100;
                PC_w          = 1'b1;
                state_next    = S_FETCH0;
            end
            default: state_next = S_RESET;
        endcase

        // Selects stay decoded from state; only the enables are gated by reset.
        if (rst) begin
            crtl_memwrite        = 1'b0;
            crtl_irwrite         = 1'b0;
            crtl_memDataRegWrite = 1'b0;
            crtl_regwrite        = 1'b0;
            crtl_rega            = 1'b0;
            crtl_regb            = 1'b0;
            crtl_regaluout       = 1'b0;
            crtl_regepc          = 1'b0;
            PC_w                 = 1'b0;
        end
    end

    assign crtl_error = err;
    assign crtl_ss    = 2'b00;
    assign state_o    = state;
endmodule
